// File: rtl/id_scoreboard_if.sv
// Decode-side bundle for the register scoreboard: issue info and read ports in,
// per-port hazards and per-register busy flags out.
interface id_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_RD     = 2,
  parameter int LAT_W      = 3
);
  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic                         stall;
  logic                         flush;
  logic                         issue_en;
  logic                         issue_gpr_we_;
  logic [REG_ADDR_W-1:0]        issue_dst;
  logic [LAT_W-1:0]             issue_lat;
  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr;
  logic                         hazard;
  logic [NUM_RD-1:0]            hazard_mask;
  logic                         pending;
  logic [NUM_REGS-1:0]          busy_vec;

  modport master (
    output stall, flush, issue_en, issue_gpr_we_, issue_dst, issue_lat, rd_en, rd_addr,
    input  hazard, hazard_mask, pending, busy_vec
  );

  modport slave (
    input  stall, flush, issue_en, issue_gpr_we_, issue_dst, issue_lat, rd_en, rd_addr,
    output hazard, hazard_mask, pending, busy_vec
  );
endinterface

// File: rtl/id_scoreboard.sv
// Per-GPR countdown scoreboard; flags RAW hazards for the instruction in decode
// against producers still in flight.
module id_scoreboard #(
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_RD      = 2,
  parameter int LAT_W       = 3,
  parameter int ZERO_REG_EN = 1
) (
  input  logic          clk,
  input  logic          reset,
  id_scoreboard_if.slave sb
);
  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic                issue_wr;
  logic [LAT_W-1:0]    issue_val;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_RD-1:0]   haz;

  always_comb begin
    issue_wr = sb.issue_en && !sb.issue_gpr_we_ &&
               ((ZERO_REG_EN == 0) || (sb.issue_dst != '0));
    // a latency of 0 behaves like 1: result is forwardable next cycle
    issue_val = (sb.issue_lat == '0) ? '0 : LAT_W'(sb.issue_lat - 1'b1);
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (sb.flush) begin
        cnt_d[r] = '0;
      end else if (!sb.stall) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
        if (issue_wr && (sb.issue_dst == REG_ADDR_W'(r))) cnt_d[r] = issue_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) cnt_q[r] <= '0;
      else       cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (cnt_q[r] != '0);
  end

  always_comb begin
    haz = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      haz[i] = sb.rd_en[i] && busy[sb.rd_addr[i*REG_ADDR_W +: REG_ADDR_W]];
    end
  end

  assign sb.busy_vec    = busy;
  assign sb.hazard_mask = haz;
  assign sb.hazard      = |haz;
  assign sb.pending     = |busy;
endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard; a second instance with ZERO_REG_EN=0 shares
// the same stimulus to cover the writable-r0 case.
module tb_id_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_scoreboard_if #(.REG_ADDR_W(5), .NUM_RD(2), .LAT_W(3)) sb0 ();
  id_scoreboard_if #(.REG_ADDR_W(5), .NUM_RD(2), .LAT_W(3)) sb1 ();

  id_scoreboard #(.REG_ADDR_W(5), .NUM_RD(2), .LAT_W(3), .ZERO_REG_EN(1)) dut0 (
    .clk(clk), .reset(reset), .sb(sb0.slave)
  );
  id_scoreboard #(.REG_ADDR_W(5), .NUM_RD(2), .LAT_W(3), .ZERO_REG_EN(0)) dut1 (
    .clk(clk), .reset(reset), .sb(sb1.slave)
  );

  assign sb1.stall         = sb0.stall;
  assign sb1.flush         = sb0.flush;
  assign sb1.issue_en      = sb0.issue_en;
  assign sb1.issue_gpr_we_ = sb0.issue_gpr_we_;
  assign sb1.issue_dst     = sb0.issue_dst;
  assign sb1.issue_lat     = sb0.issue_lat;
  assign sb1.rd_en         = sb0.rd_en;
  assign sb1.rd_addr       = sb0.rd_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb0.stall         = 1'b0;
    sb0.flush         = 1'b0;
    sb0.issue_en      = 1'b0;
    sb0.issue_gpr_we_ = 1'b1;
    sb0.issue_dst     = '0;
    sb0.issue_lat     = '0;
    sb0.rd_en         = '0;
    sb0.rd_addr       = '0;
  endtask

  task automatic issue(input logic [4:0] dst, input logic [2:0] lat, input logic we_n);
    sb0.issue_en      = 1'b1;
    sb0.issue_gpr_we_ = we_n;
    sb0.issue_dst     = dst;
    sb0.issue_lat     = lat;
  endtask

  initial begin
    // reset then idle
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    sb0.rd_en   = 2'b11;
    sb0.rd_addr = {5'd3, 5'd4};
    #1;
    check("rst_hazard", 32'(sb0.hazard), 32'd0);
    check("rst_mask", 32'(sb0.hazard_mask), 32'd0);
    check("rst_pending", 32'(sb0.pending), 32'd0);
    check("rst_busy", sb0.busy_vec, 32'd0);

    // load-use: one bubble
    idle();
    issue(5'd5, 3'd2, 1'b0);
    tick();
    idle();
    sb0.rd_en   = 2'b01;
    sb0.rd_addr = {5'd0, 5'd5};
    #1;
    check("lu_mask", 32'(sb0.hazard_mask), 32'h1);
    check("lu_hazard", 32'(sb0.hazard), 32'd1);
    tick();
    #1;
    check("lu_mask_after", 32'(sb0.hazard_mask), 32'h0);

    // long latency with a two-cycle stall
    idle();
    issue(5'd7, 3'd5, 1'b0);
    tick();
    idle();
    sb0.rd_en   = 2'b10;
    sb0.rd_addr = {5'd7, 5'd0};
    for (int c = 1; c <= 7; c++) begin
      sb0.stall = (c == 2) || (c == 3);
      #1;
      check($sformatf("long_busy7_c%0d", c), 32'(sb0.busy_vec[7]), (c <= 6) ? 32'd1 : 32'd0);
      check($sformatf("long_mask_c%0d", c), 32'(sb0.hazard_mask), (c <= 6) ? 32'h2 : 32'h0);
      tick();
    end

    // flush beats a simultaneous issue
    idle();
    issue(5'd9, 3'd4, 1'b0);
    tick();
    idle();
    issue(5'd10, 3'd4, 1'b0);
    sb0.flush = 1'b1;
    #1;
    check("fl_busy9_pre", 32'(sb0.busy_vec[9]), 32'd1);
    check("fl_pending_pre", 32'(sb0.pending), 32'd1);
    tick();
    idle();
    #1;
    check("fl_busy", sb0.busy_vec, 32'd0);
    check("fl_pending", 32'(sb0.pending), 32'd0);

    // r0 destination: hardwired in dut0, writable in dut1
    idle();
    issue(5'd0, 3'd4, 1'b0);
    tick();
    idle();
    sb0.rd_en   = 2'b01;
    sb0.rd_addr = '0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("z_busy0_c%0d", c), 32'(sb0.busy_vec[0]), 32'd0);
      check($sformatf("z_haz_c%0d", c), 32'(sb0.hazard), 32'd0);
      check($sformatf("nz_busy0_c%0d", c), 32'(sb1.busy_vec[0]), (c <= 3) ? 32'd1 : 32'd0);
      check($sformatf("nz_haz_c%0d", c), 32'(sb1.hazard), (c <= 3) ? 32'd1 : 32'd0);
      tick();
    end

    // we_ deasserted: no tracking
    idle();
    issue(5'd6, 3'd4, 1'b1);
    tick();
    idle();
    #1;
    check("we_busy6", 32'(sb0.busy_vec[6]), 32'd0);
    check("we_pending", 32'(sb0.pending), 32'd0);

    // WAW overwrite with a shorter latency
    idle();
    issue(5'd12, 3'd7, 1'b0);
    tick();
    issue(5'd12, 3'd2, 1'b0);
    #1;
    check("waw_busy12_first", 32'(sb0.busy_vec[12]), 32'd1);
    tick();
    idle();
    sb0.rd_en   = 2'b11;
    sb0.rd_addr = {5'd12, 5'd12};
    #1;
    check("waw_mask_dual", 32'(sb0.hazard_mask), 32'h3);
    check("waw_busy_onehot", sb0.busy_vec, 32'h0000_1000);
    tick();
    #1;
    check("waw_busy12_clear", 32'(sb0.busy_vec[12]), 32'd0);
    check("waw_mask_clear", 32'(sb0.hazard_mask), 32'h0);

    // latency 1 and latency 0 never mark busy
    idle();
    issue(5'd3, 3'd1, 1'b0);
    tick();
    idle();
    #1;
    check("lat1_busy", sb0.busy_vec, 32'd0);
    issue(5'd4, 3'd0, 1'b0);
    tick();
    idle();
    #1;
    check("lat0_pending", 32'(sb0.pending), 32'd0);

    // issue during stall is ignored
    idle();
    issue(5'd8, 3'd3, 1'b0);
    sb0.stall = 1'b1;
    tick();
    idle();
    #1;
    check("stall_issue_busy", sb0.busy_vec, 32'd0);

    // reset mid-operation
    idle();
    issue(5'd20, 3'd7, 1'b0);
    tick();
    idle();
    #1;
    check("mid_busy20", sb0.busy_vec, 32'h0010_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_busy", sb0.busy_vec, 32'd0);
    check("mid_rst_pending1", 32'(sb1.pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
